// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin front end for the single sdram_controller request/ack port.
// One transaction in flight; commands latched at grant, acks and read data registered.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W         = 22,
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_ack,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ack,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              owrite_req,
    output logic              oread_req,
    output logic [ADDR_W-1:0] oaddress,
    output logic [DATA_W-1:0] owdata,
    input  logic              iwrite_ack,
    input  logic              iread_ack,
    input  logic [DATA_W-1:0] iread_data,
    output logic [1:0]        ogrant,
    output logic              otimeout
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRel} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;      // client favoured when both request
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic [1:0]        grant_q, grant_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              timeout_q, timeout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              win;
    logic              matched;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        grant_d   = grant_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        win       = (c0_req && c1_req) ? ptr_q : c1_req;
        matched   = we_q ? iwrite_ack : iread_ack;

        unique case (state_q)
            StIdle: begin
                if (c0_req || c1_req) begin
                    owner_d  = win;
                    we_d     = win ? c1_we : c0_we;
                    addr_d   = win ? c1_addr : c0_addr;
                    wdata_d  = win ? c1_wdata : c0_wdata;
                    wr_req_d = win ? c1_we : c0_we;
                    rd_req_d = win ? ~c1_we : ~c0_we;
                    grant_d  = win ? 2'b10 : 2'b01;
                    cnt_d    = '0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (matched || cnt_q == CntLast) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    ack0_d   = ~owner_q;
                    ack1_d   = owner_q;
                    state_d  = StWaitRel;
                    // A real ack wins over a timeout landing on the same cycle.
                    if (matched) begin
                        if (!we_q && !owner_q) rdata0_d = iread_data;
                        if (!we_q && owner_q)  rdata1_d = iread_data;
                    end else begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitRel: begin
                if (!iwrite_ack && !iread_ack) begin
                    grant_d = 2'b00;
                    ptr_d   = ~owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q   <= StIdle;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            grant_q   <= 2'b00;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            grant_q   <= grant_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign owrite_req = wr_req_q;
    assign oread_req  = rd_req_q;
    assign oaddress   = addr_q;
    assign owdata     = wdata_q;
    assign ogrant     = grant_q;
    assign otimeout   = timeout_q;
    assign c0_ack     = ack0_q;
    assign c1_ack     = ack1_q;
    assign c0_rdata   = rdata0_q;
    assign c1_rdata   = rdata1_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized scoreboard bench for sdram_port_arbiter: a transaction-level model predicts grant
// order, commands, request length, ack and read data; a controller stub plays the sdram side.
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 128;
    localparam int TO     = 16;

    typedef struct {
        int                cid;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int                delay;
        int                hold;
        bit                to;
    } txn_t;

    logic              iclk = 1'b0;
    logic              ireset_n = 1'b0;
    logic              c0_req, c0_we, c1_req, c1_we;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic [DATA_W-1:0] c0_wdata, c1_wdata;
    logic              c0_ack, c1_ack;
    logic [DATA_W-1:0] c0_rdata, c1_rdata;
    logic              owrite_req, oread_req;
    logic [ADDR_W-1:0] oaddress;
    logic [DATA_W-1:0] owdata;
    logic              iwrite_ack, iread_ack;
    logic [DATA_W-1:0] iread_data;
    logic [1:0]        ogrant;
    logic              otimeout;

    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];
    txn_t plan_q[$];
    logic [DATA_W-1:0] mem_m[8];
    logic [DATA_W-1:0] stub_mem[8];
    logic [DATA_W-1:0] rdata_m[2];
    int   last_served;
    bit   to_m;
    bit   mon_en = 1'b0;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .iclk(iclk), .ireset_n(ireset_n),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_ack(c0_ack), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_ack(c1_ack), .c1_rdata(c1_rdata),
        .owrite_req(owrite_req), .oread_req(oread_req), .oaddress(oaddress), .owdata(owdata),
        .iwrite_ack(iwrite_ack), .iread_ack(iread_ack), .iread_data(iread_data),
        .ogrant(ogrant), .otimeout(otimeout)
    );

    always #5 iclk = ~iclk;

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level outcome: memory, per-client read data, sticky timeout, fairness.
    task automatic model(inout txn_t x);
        if (x.to) to_m = 1'b1;
        else if (x.we) mem_m[x.addr[2:0]] = x.wdata;
        else rdata_m[x.cid] = mem_m[x.addr[2:0]];
        x.rdata = rdata_m[x.cid];
        last_served = x.cid;
        exp_q.push_back(x);
        plan_q.push_back(x);
    endtask

    task automatic client_wait(input int id);
        bit got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge iclk);
            if (id == 0 ? c0_ack : c1_ack) begin
                got = 1'b1;
                if (id == 0) c0_req = 1'b0; else c1_req = 1'b0;
            end
        end
        chk(id == 0 ? "c0_ack_seen" : "c1_ack_seen", DATA_W'(got), 1);
        if (id == 0) c0_req = 1'b0; else c1_req = 1'b0;
    endtask

    task automatic run_round(input bit force_both, input bit force_to);
        int   sel;
        int   first;
        bit   r0, r1;
        txn_t t[2];
        sel = force_both ? 3 : int'($urandom_range(1, 3));
        r0  = (sel & 1) != 0;
        r1  = (sel & 2) != 0;
        for (int i = 0; i < 2; i++) begin
            t[i].cid   = i;
            t[i].we    = 1'($urandom_range(0, 1));
            t[i].addr  = ADDR_W'($urandom_range(0, 7));
            t[i].wdata = rand_data();
            t[i].to    = force_to || ($urandom_range(0, 9) == 0);
            t[i].delay = t[i].to ? TO : int'($urandom_range(1, 12));
            t[i].hold  = $urandom_range(1, 5);
            t[i].rdata = '0;
        end
        first = (r0 && r1) ? (last_served == 0 ? 1 : 0) : (r0 ? 0 : 1);
        model(t[first]);
        if (r0 && r1) model(t[1 - first]);
        @(negedge iclk);
        c0_req = r0; c0_we = t[0].we; c0_addr = t[0].addr; c0_wdata = t[0].wdata;
        c1_req = r1; c1_we = t[1].we; c1_addr = t[1].addr; c1_wdata = t[1].wdata;
        fork
            if (r0) client_wait(0);
            if (r1) client_wait(1);
        join
        repeat (8) @(negedge iclk);
        chk("idle_grant", DATA_W'(ogrant), 0);
        chk("otimeout", DATA_W'(otimeout), DATA_W'(to_m));
        chk("c0_rdata_held", c0_rdata, rdata_m[0]);
        chk("c1_rdata_held", c1_rdata, rdata_m[1]);
        chk("exp_drained", DATA_W'(exp_q.size()), 0);
    endtask

    // Controller stub: acks after the planned delay, holds ack, adds noise on the other ack.
    initial begin
        iwrite_ack = 1'b0;
        iread_ack  = 1'b0;
        iread_data = '0;
        forever begin
            @(negedge iclk);
            if (owrite_req || oread_req) begin
                txn_t p;
                bit   was_we;
                int   seen;
                was_we = owrite_req;
                chk("stub_plan_avail", DATA_W'(plan_q.size() != 0), 1);
                if (plan_q.size() != 0) p = plan_q.pop_front();
                else p.to = 1'b1;
                iread_data = rand_data();
                if (!p.to) begin
                    seen = 1;
                    while (seen < p.delay && (owrite_req || oread_req)) begin
                        if (was_we) iread_ack = ($urandom_range(0, 3) == 0);
                        else iwrite_ack = ($urandom_range(0, 3) == 0);
                        @(negedge iclk);
                        seen++;
                    end
                    iwrite_ack = 1'b0;
                    iread_ack  = 1'b0;
                    if (owrite_req || oread_req) begin
                        if (was_we) begin
                            stub_mem[oaddress[2:0]] = owdata;
                            iwrite_ack = 1'b1;
                        end else begin
                            iread_data = stub_mem[oaddress[2:0]];
                            iread_ack  = 1'b1;
                        end
                        repeat (p.hold) @(negedge iclk);
                        iwrite_ack = 1'b0;
                        iread_ack  = 1'b0;
                        iread_data = rand_data();
                    end
                end else begin
                    for (int k = 0; k < 1000 && (owrite_req || oread_req); k++) @(negedge iclk);
                end
            end
        end
    end

    // Monitor: pops the expected transaction when a controller request appears.
    initial begin
        bit   active = 1'b0;
        int   hi = 0;
        txn_t cur;
        forever begin
            @(negedge iclk);
            if (!mon_en) begin
                active = 1'b0;
            end else if (!active) begin
                if (c0_ack || c1_ack) chk("stray_ack", DATA_W'({c1_ack, c0_ack}), 0);
                if (owrite_req || oread_req) begin
                    chk("exp_avail", DATA_W'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur    = exp_q.pop_front();
                        active = 1'b1;
                        hi     = 1;
                        chk("cmd", DATA_W'({owrite_req, oread_req}), DATA_W'({cur.we, !cur.we}));
                        chk("addr", DATA_W'(oaddress), DATA_W'(cur.addr));
                        if (cur.we) chk("wdata", owdata, cur.wdata);
                        chk("grant", DATA_W'(ogrant), cur.cid == 1 ? 2 : 1);
                    end
                end
            end else if (owrite_req || oread_req) begin
                hi++;
                if (c0_ack || c1_ack) chk("early_ack", DATA_W'({c1_ack, c0_ack}), 0);
            end else begin
                active = 1'b0;
                chk("req_len", DATA_W'(hi), DATA_W'(cur.delay));
                chk("ack", DATA_W'({c1_ack, c0_ack}), cur.cid == 1 ? 2 : 1);
                chk("rdata", cur.cid == 1 ? c1_rdata : c0_rdata, cur.rdata);
                if (cur.to) chk("timeout_set", DATA_W'(otimeout), 1);
            end
        end
    end

    initial begin
        txn_t rt;
        c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            mem_m[i]    = '0;
            stub_mem[i] = '0;
        end
        rdata_m[0] = '0; rdata_m[1] = '0;
        last_served = 1;
        to_m = 1'b0;
        repeat (3) @(negedge iclk);
        chk("rst_reqs", DATA_W'({owrite_req, oread_req}), 0);
        chk("rst_grant", DATA_W'(ogrant), 0);
        chk("rst_acks", DATA_W'({c1_ack, c0_ack}), 0);
        chk("rst_timeout", DATA_W'(otimeout), 0);
        chk("rst_c0_rdata", c0_rdata, 0);
        chk("rst_c1_rdata", c1_rdata, 0);
        ireset_n = 1'b1;
        @(negedge iclk);
        mon_en = 1'b1;
        for (int r = 0; r < 40; r++) run_round(r < 4, r == 6);

        // Reset while a read is outstanding.
        mon_en = 1'b0;
        rt.cid = 0; rt.we = 1'b0; rt.addr = ADDR_W'(3); rt.wdata = '0; rt.rdata = '0;
        rt.delay = TO; rt.hold = 1; rt.to = 1'b1;
        plan_q.push_back(rt);
        @(negedge iclk);
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = ADDR_W'(3);
        repeat (4) @(negedge iclk);
        chk("pre_rst_read_req", DATA_W'(oread_req), 1);
        chk("pre_rst_grant", DATA_W'(ogrant), 1);
        chk("pre_rst_timeout", DATA_W'(otimeout), 1);
        ireset_n = 1'b0;
        #1;
        chk("mid_rst_reqs", DATA_W'({owrite_req, oread_req}), 0);
        chk("mid_rst_grant", DATA_W'(ogrant), 0);
        chk("mid_rst_acks", DATA_W'({c1_ack, c0_ack}), 0);
        chk("mid_rst_timeout", DATA_W'(otimeout), 0);
        chk("mid_rst_c0_rdata", c0_rdata, 0);
        chk("mid_rst_c1_rdata", c1_rdata, 0);
        c0_req = 1'b0;
        repeat (3) @(negedge iclk);
        ireset_n = 1'b1;
        rdata_m[0] = '0; rdata_m[1] = '0;
        last_served = 1;
        to_m = 1'b0;
        @(negedge iclk);
        mon_en = 1'b1;
        run_round(1'b1, 1'b0);
        run_round(1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
